poly_scan_gen: RTL and testbench
================================

POLY_SCAN_GEN -- requirements
Module: poly_scan_gen

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 1280, horizontal screen size in pixels.
REQ-002 SHALL have parameter PIXEL_HEIGHT, default 720, vertical screen size in pixels.
REQ-003 SHALL have parameter MAX_NUM_VERTICES, default 4, number of polygon vertices.
REQ-004 SHALL have port clk_in  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_in  input  1  request to scan the polygon on xs_in/ys_in.
REQ-007 SHALL have port xs_in  input  signed 32 x MAX_NUM_VERTICES  vertex x coordinates.
REQ-008 SHALL have port ys_in  input  signed 32 x MAX_NUM_VERTICES  vertex y coordinates.
REQ-009 SHALL have port hcount_out  output  $clog2(PIXEL_WIDTH)  pixel x of the current beat.
REQ-010 SHALL have port vcount_out  output  $clog2(PIXEL_HEIGHT)  pixel y of the current beat.
REQ-011 SHALL have port valid_out  output  1  hcount_out/vcount_out carry a pixel.
REQ-012 SHALL have port ready_in  input  1  downstream point-in-polygon tester accepts the beat.
REQ-013 SHALL have port last_out  output  1  marks the final pixel of the scan.
REQ-014 SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done_out  output  1  one-cycle pulse at scan end.
REQ-016 SHALL have port empty_out  output  1  valid with done_out; clipped bounding box is empty.

Function
REQ-017 SHALL implement FSM states IDLE, MINMAX, CLIP, SCAN, DONE.
REQ-018 In IDLE, start_in high SHALL register all vertices, set index 0 and go to MINMAX; start_in SHALL be ignored in every other state.
REQ-019 Vertex inputs SHALL be sampled only at the accepting edge; later changes SHALL have no effect on the scan.
REQ-020 MINMAX SHALL fold one vertex per cycle into signed xmin/xmax/ymin/ymax, initialised from vertex 0, over exactly MAX_NUM_VERTICES cycles, then go to CLIP.
REQ-021 CLIP SHALL take one cycle: clamp x to [0, PIXEL_WIDTH-1] and y to [0, PIXEL_HEIGHT-1] in 32-bit signed arithmetic; if xmax<0, ymax<0, xmin>PIXEL_WIDTH-1 or ymin>PIXEL_HEIGHT-1, go to DONE with empty flag set, otherwise go to SCAN.
REQ-022 The first valid_out SHALL appear MAX_NUM_VERTICES+2 cycles after the edge that accepted start_in.
REQ-023 SCAN SHALL emit raster order: x from xmin to xmax, then y+1, from (xmin,ymin) to (xmax,ymax), with valid_out continuously high.
REQ-024 A beat SHALL advance only on valid_out&&ready_in; while ready_in is low, hcount_out, vcount_out and last_out SHALL stay stable.
REQ-025 last_out SHALL be high only on beat (xmax,ymax); a 1x1 box SHALL emit one beat with last_out high.
REQ-026 The handshake of the last beat SHALL move the FSM to DONE; DONE SHALL last one cycle with done_out=1, then return to IDLE.
REQ-027 empty_out SHALL equal the empty flag during DONE and 0 otherwise; no valid_out in an empty scan.

Reset
REQ-028 rst_n_in low SHALL asynchronously force IDLE and drive valid_out, last_out, busy_out, done_out, empty_out, hcount_out and vcount_out to 0, including mid-scan.
REQ-029 After reset release, the first start_in SHALL be honoured on the next rising edge.

Configuration
REQ-030 With POLY_SCAN_STATS_EN defined, the block SHALL add output pixel_count_out [31:0], cleared on start acceptance, incremented per handshake, held after DONE, reset to 0.
REQ-031 Without POLY_SCAN_STATS_EN, the port and counter SHALL be absent and the rest of the behaviour identical.

Structure
REQ-032 Package poly_pkg SHALL hold the FSM state enum, the signed 32-bit coordinate typedef and the screen clamp helper constants.
REQ-033 The min/max fold SHALL live in sub-module bbox_accum (clear, enable, coordinate in, four extrema out).

Verification
REQ-034 Square (10,10),(13,10),(13,12),(10,12), ready_in=1 -> 12 beats (10,10)..(13,12) raster order, last on (13,12), done_out next cycle, empty_out 0.
REQ-035 Same square with ready_in toggling 1,0,0,1 -> no dropped or duplicated beats; outputs stable while ready_in low.
REQ-036 (-5,-5),(2,-5),(2,1),(-5,1) -> 6 beats x 0..2, y 0..1.
REQ-037 All vertices x>=1280 -> no valid_out; done_out=1 with empty_out=1 at cycle MAX_NUM_VERTICES+2.
REQ-038 start_in pulsed during SCAN -> ignored; rst_n_in low mid-SCAN -> valid_out and busy_out 0 before the next clock edge.
REQ-039 With POLY_SCAN_STATS_EN, the REQ-034 stimulus -> pixel_count_out=12 after done_out.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared types and helpers for the polygon bounding-box scan generator.
package poly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MINMAX,
    ST_CLIP,
    ST_SCAN,
    ST_DONE
  } state_e;

  typedef logic signed [31:0] coord_t;

  localparam coord_t COORD_LO = 32'sd0;

  // Saturate a signed coordinate into [COORD_LO, hi].
  function automatic coord_t clamp_coord(input coord_t v, input coord_t hi);
    if (v < COORD_LO) return COORD_LO;
    if (v > hi)       return hi;
    return v;
  endfunction

endpackage

// File: rtl/bbox_accum.sv
// Signed min/max fold of a stream of (x,y) points; clear loads the first point.
module bbox_accum
  import poly_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_n_in,
  input  logic   clear_in,
  input  logic   en_in,
  input  coord_t x_in,
  input  coord_t y_in,
  output coord_t xmin_out,
  output coord_t xmax_out,
  output coord_t ymin_out,
  output coord_t ymax_out
);

  coord_t xmin_q, xmax_q, ymin_q, ymax_q;
  coord_t xmin_d, xmax_d, ymin_d, ymax_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (en_in) begin
      if (clear_in) begin
        xmin_d = x_in;
        xmax_d = x_in;
        ymin_d = y_in;
        ymax_d = y_in;
      end else begin
        if (x_in < xmin_q) xmin_d = x_in;
        if (x_in > xmax_q) xmax_d = x_in;
        if (y_in < ymin_q) ymin_d = y_in;
        if (y_in > ymax_q) ymax_d = y_in;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  assign xmin_out = xmin_q;
  assign xmax_out = xmax_q;
  assign ymin_out = ymin_q;
  assign ymax_out = ymax_q;

endmodule

// File: rtl/poly_scan_gen.sv
// Raster-scans the screen-clipped bounding box of a polygon with a valid/ready stream.
// Optional pixel counter output enabled by defining POLY_SCAN_STATS_EN.
module poly_scan_gen
  import poly_pkg::*;
#(
  parameter int PIXEL_WIDTH      = 1280,
  parameter int PIXEL_HEIGHT     = 720,
  parameter int MAX_NUM_VERTICES = 4,
  localparam int HW    = $clog2(PIXEL_WIDTH),
  localparam int VW    = $clog2(PIXEL_HEIGHT),
  localparam int IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  coord_t        xs_in [MAX_NUM_VERTICES],
  input  coord_t        ys_in [MAX_NUM_VERTICES],
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          valid_out,
  input  logic          ready_in,
  output logic          last_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          empty_out
`ifdef POLY_SCAN_STATS_EN
  ,
  output logic [31:0]   pixel_count_out
`endif
);

  localparam coord_t X_HI = coord_t'(PIXEL_WIDTH - 1);
  localparam coord_t Y_HI = coord_t'(PIXEL_HEIGHT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_NUM_VERTICES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HW-1:0]    hcount_q, hcount_d, x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [VW-1:0]    vcount_q, vcount_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d, empty_q, empty_d;
  logic             accept, fire;

  coord_t xs_q [MAX_NUM_VERTICES];
  coord_t ys_q [MAX_NUM_VERTICES];
  coord_t xmin, xmax, ymin, ymax;
  coord_t xmin_c, xmax_c, ymin_c, ymax_c;
  logic   box_empty;

  assign accept = (state_q == ST_IDLE) && start_in;
  assign fire   = valid_q && ready_in;

  // NOTE: vertex storage is a plain register file with no reset; it is always written before use.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      xs_q <= xs_in;
      ys_q <= ys_in;
    end
  end

  bbox_accum u_bbox (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (idx_q == '0),
    .en_in    (state_q == ST_MINMAX),
    .x_in     (xs_q[idx_q]),
    .y_in     (ys_q[idx_q]),
    .xmin_out (xmin),
    .xmax_out (xmax),
    .ymin_out (ymin),
    .ymax_out (ymax)
  );

  always_comb begin
    xmin_c    = clamp_coord(xmin, X_HI);
    xmax_c    = clamp_coord(xmax, X_HI);
    ymin_c    = clamp_coord(ymin, Y_HI);
    ymax_c    = clamp_coord(ymax, Y_HI);
    box_empty = (xmax < COORD_LO) || (ymax < COORD_LO) || (xmin > X_HI) || (ymin > Y_HI);

    state_d  = state_q;
    idx_d    = idx_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    x_lo_d   = x_lo_q;
    x_hi_d   = x_hi_q;
    y_lo_d   = y_lo_q;
    y_hi_d   = y_hi_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    empty_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_MINMAX;
        end
      end
      ST_MINMAX: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_CLIP;
      end
      ST_CLIP: begin
        if (box_empty) begin
          done_d  = 1'b1;
          empty_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          x_lo_d   = xmin_c[HW-1:0];
          x_hi_d   = xmax_c[HW-1:0];
          y_lo_d   = ymin_c[VW-1:0];
          y_hi_d   = ymax_c[VW-1:0];
          hcount_d = xmin_c[HW-1:0];
          vcount_d = ymin_c[VW-1:0];
          valid_d  = 1'b1;
          last_d   = (xmin_c == xmax_c) && (ymin_c == ymax_c);
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (fire) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            if (hcount_q == x_hi_q) begin
              hcount_d = x_lo_q;
              vcount_d = vcount_q + VW'(1);
            end else begin
              hcount_d = hcount_q + HW'(1);
            end
            last_d = (hcount_d == x_hi_q) && (vcount_d == y_hi_q);
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      x_lo_q   <= '0;
      x_hi_q   <= '0;
      y_lo_q   <= '0;
      y_hi_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      x_lo_q   <= x_lo_d;
      x_hi_q   <= x_hi_d;
      y_lo_q   <= y_lo_d;
      y_hi_q   <= y_hi_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      empty_q  <= empty_d;
    end
  end

`ifdef POLY_SCAN_STATS_EN
  logic [31:0] pixel_count_q, pixel_count_d;

  always_comb begin
    pixel_count_d = pixel_count_q;
    if (accept)                           pixel_count_d = '0;
    else if (fire && state_q == ST_SCAN)  pixel_count_d = pixel_count_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pixel_count_q <= '0;
    else           pixel_count_q <= pixel_count_d;
  end

  assign pixel_count_out = pixel_count_q;
`endif

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign valid_out  = valid_q;
  assign last_out   = last_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign empty_out  = empty_q;

endmodule

// File: tb/tb_poly_scan_gen.sv
// Directed bench for poly_scan_gen: raster order, backpressure, clipping, empty box, reset.
module tb_poly_scan_gen;
  import poly_pkg::*;

  localparam int N  = 4;
  localparam int HW = $clog2(1280);
  localparam int VW = $clog2(720);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  coord_t        xs [N];
  coord_t        ys [N];
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          valid, last, busy, done, empty;
`ifdef POLY_SCAN_STATS_EN
  logic [31:0]   pixel_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  poly_scan_gen #(.PIXEL_WIDTH(1280), .PIXEL_HEIGHT(720), .MAX_NUM_VERTICES(N)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .start_in   (start),
    .xs_in      (xs),
    .ys_in      (ys),
    .hcount_out (hcount),
    .vcount_out (vcount),
    .valid_out  (valid),
    .ready_in   (ready),
    .last_out   (last),
    .busy_out   (busy),
    .done_out   (done),
    .empty_out  (empty)
`ifdef POLY_SCAN_STATS_EN
    ,
    .pixel_count_out (pixel_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_poly(input int x0, y0, x1, y1, x2, y2, x3, y3);
    xs[0] = x0; ys[0] = y0;
    xs[1] = x1; ys[1] = y1;
    xs[2] = x2; ys[2] = y2;
    xs[3] = x3; ys[3] = y3;
  endtask

  // Accept start at the next edge, then check the N setup cycles (MINMAX) before CLIP.
  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_poly(900, 900, -900, -900, 3, 3, 600, 100);
    check("busy_after_accept", busy, 1);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      check("no_valid_setup", valid, 0);
    end
    @(negedge clk);
    check("no_valid_clip", valid, 0);
    check("no_done_clip", done, 0);
    @(negedge clk);
  endtask

  // Expect raster beats over the box; ready follows 1,0,0,1 when toggling.
  task automatic run_scan(input int x0, x1, y0, y1, input bit toggle);
    int  k = 0;
    bit  rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        do begin
          rdy   = toggle ? pat[3 - (k % 4)] : 1'b1;
          ready = rdy;
          k++;
          check("valid", valid, 1);
          check("hcount", hcount, x);
          check("vcount", vcount, y);
          check("last", last, (x == x1 && y == y1));
          @(negedge clk);
          start = 1'b0;
        end while (!rdy);
      end
    end
    ready = 1'b1;
    check("done_pulse", done, 1);
    check("valid_after_last", valid, 0);
    check("empty_nonempty", empty, 0);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    set_poly(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_empty", empty, 0);
    check("rst_last", last, 0);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Square, full throughput
    set_poly(10, 10, 13, 10, 13, 12, 10, 12);
    launch();
    run_scan(10, 13, 10, 12, 1'b0);
`ifdef POLY_SCAN_STATS_EN
    check("pixel_count_12", pixel_count, 12);
`endif

    // Square with backpressure
    set_poly(10, 10, 13, 10, 13, 12, 10, 12);
    launch();
    run_scan(10, 13, 10, 12, 1'b1);

    // Negative coordinates clipped to the origin
    set_poly(-5, -5, 2, -5, 2, 1, -5, 1);
    launch();
    run_scan(0, 2, 0, 1, 1'b0);

    // Single-pixel box, with a start pulse during the scan that must be ignored
    set_poly(7, 3, 7, 3, 7, 3, 7, 3);
    launch();
    set_poly(100, 100, 200, 100, 200, 200, 100, 200);
    start = 1'b1;
    run_scan(7, 7, 3, 3, 1'b0);

    // Fully off-screen to the right: empty scan
    set_poly(1280, 0, 1300, 5, 2000, 5, 1280, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      check("empty_no_done_early", done, 0);
    end
    @(negedge clk);
    check("empty_done", done, 1);
    check("empty_flag", empty, 1);
    check("empty_no_valid", valid, 0);
    @(negedge clk);
    check("empty_flag_clear", empty, 0);
    check("empty_idle", busy, 0);

    // Reset in the middle of a scan
    set_poly(10, 10, 13, 10, 13, 12, 10, 12);
    launch();
    check("pre_rst_valid", valid, 1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_hcount", hcount, 12);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_hcount", hcount, 0);
    check("midrst_vcount", vcount, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_after_rst", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
